ct_f_spsram_1024x128_ctrl: RTL and testbench

- Access controller directly upstream of the 1024x128 single-port SRAM macro wrapper. Drives the macro's active-low controls and captures its read data.
- Zero-initialises the whole array after reset.
- Accepts one valid/ready request per cycle, read or write.
- Returns read data through a small response FIFO, so consumer back-pressure never drops or corrupts data.

---
 rtl/ct_f_spsram_1024x128_ctrl.sv | 80 ++++++++
 tb/tb_ct_f_spsram_1024x128_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_1024x128_ctrl.sv
// ct_f_spsram_1024x128_ctrl: clears a 1024x128 single-port SRAM after reset, then serves valid/ready reads/writes with read data returned through a credit-guarded response FIFO.
// Ports: CLK/RST (async active-high); init_done; req_* request channel (req_rdy combinational from rsp_rdy);
//        rsp_* response channel (FIFO head); sram_* active-low macro controls, address, write data and registered read data.
module ct_f_spsram_1024x128_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_clr, r_a;
  logic [DATA_WIDTH-1:0] r_d;
  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic r_infl;
  logic w_acc, w_pop;
  assign w_pop    = rsp_vld && rsp_rdy;
  assign w_acc    = req_vld && req_rdy;
  assign rsp_vld  = r_cnt != '0;
  assign rsp_data = r_mem[r_rp];
  // Credit counts the in-flight read as occupied so its push can never overflow; a same-cycle pop frees a slot.
  assign req_rdy  = r_state == RUN &&
                    ({1'b0, r_cnt} + (CW+1)'(r_infl) - (CW+1)'(w_pop)) < (CW+1)'(RSP_DEPTH);
  always_comb begin
    w_next    = (r_state == INIT && r_clr == '1) ? RUN : r_state;
    init_done = r_state == RUN;
    sram_cen  = !(r_state == INIT || w_acc);
    sram_gwen = r_state == RUN && !(w_acc && req_wr);
    sram_wen  = {DATA_WIDTH{sram_gwen}};
    sram_a    = r_state == INIT ? r_clr : w_acc ? req_addr : r_a;
    sram_d    = r_state == INIT ? '0 : (w_acc && req_wr) ? req_wdata : r_d;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= INIT;
    else     r_state <= w_next;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_clr  <= '0;
      r_a    <= '0;
      r_d    <= '0;
      r_infl <= 1'b0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (r_state == INIT) r_clr <= r_clr + 1'b1;
      r_a    <= sram_a;
      r_d    <= sram_d;
      r_infl <= w_acc && !req_wr;
      if (r_infl) begin
        r_mem[r_wp] <= sram_q;
        r_wp <= r_wp == PW'(RSP_DEPTH - 1) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp == PW'(RSP_DEPTH - 1) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(r_infl) - CW'(w_pop);
    end
  always_ff @(posedge CLK) assert (r_cnt <= CW'(RSP_DEPTH));
endmodule

// File: tb/tb_ct_f_spsram_1024x128_ctrl.sv
// tb_ct_f_spsram_1024x128_ctrl: randomized self-checking bench with an SRAM macro model and a queue-based reference of the controller.
module tb_ct_f_spsram_1024x128_ctrl;
  logic         CLK = 0, RST = 1;
  logic         init_done, req_vld = 0, req_rdy, req_wr = 0, rsp_vld, rsp_rdy = 0;
  logic [9:0]   req_addr = 0, sram_a;
  logic [127:0] req_wdata = 0, rsp_data, sram_wen, sram_d, sram_q;
  logic         sram_cen, sram_gwen;
  logic [127:0] macro_mem [1024];
  logic [127:0] ref_mem [1024];
  typedef struct {logic [127:0] d; int t;} rsp_t;
  rsp_t exp_q [$];
  int checks = 0, errors = 0, cyc = 0;
  logic [9:0]   prev_a;
  logic [127:0] prev_d;

  ct_f_spsram_1024x128_ctrl dut (
    .CLK(CLK), .RST(RST), .init_done(init_done),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (!sram_cen) begin
      if (!sram_gwen) macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= macro_mem[sram_a];
    end

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < 1024; i++) begin
      req_vld = 1;
      #1;
      chk("sweep", {110'd0, init_done, req_rdy, rsp_vld, sram_cen, sram_gwen, |sram_wen, sram_a, |sram_d},
                   {110'd0, 6'b0, 10'(i), 1'b0});
      prev_a = 10'(i);
      prev_d = '0;
      @(negedge CLK);
    end
    req_vld = 0;
    #1;
    chk("init_done", {126'd0, init_done, req_rdy}, 128'd3);
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
  endtask

  task automatic cycle(input logic v, input logic w, input logic [9:0] a, input logic [127:0] d, input logic rr);
    logic ev, ep, er;
    rsp_t e;
    req_vld = v; req_wr = w; req_addr = a; req_wdata = d; rsp_rdy = rr;
    #1;
    ev = exp_q.size() > 0 && exp_q[0].t <= cyc;
    ep = ev && rr;
    er = (exp_q.size() - int'(ep)) < 2;
    chk("rsp_vld", {127'd0, rsp_vld}, {127'd0, ev});
    chk("req_rdy", {127'd0, req_rdy}, {127'd0, er});
    if (ep) chk("rsp_data", rsp_data, exp_q[0].d);
    if (v && er) begin
      chk("ctl", {124'd0, sram_cen, sram_gwen, &sram_wen, |sram_wen}, {124'd0, 1'b0, !w, !w, !w});
      chk("addr", {118'd0, sram_a}, {118'd0, a});
      if (w) chk("wdata", sram_d, d);
      prev_a = a;
      prev_d = w ? d : sram_d;
    end else begin
      chk("idle", {124'd0, sram_cen, sram_gwen, &sram_wen, |sram_wen}, 128'hF);
      chk("hold", {sram_a, sram_d[117:0]}, {prev_a, prev_d[117:0]});
    end
    @(posedge CLK);
    if (ep) void'(exp_q.pop_front());
    if (v && er && w) ref_mem[a] = d;
    if (v && er && !w) begin
      e.d = ref_mem[a];
      e.t = cyc + 2;
      exp_q.push_back(e);
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) macro_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(negedge CLK);
    chk("rst", {121'd0, init_done, req_rdy, rsp_vld, sram_cen, sram_gwen, |sram_wen, |sram_d}, 128'd0);
    chk("rst_a", {118'd0, sram_a}, 128'd0);
    chk("rst_data", rsp_data, 128'd0);
    RST = 0;
    sweep();
    cycle(1, 0, 10'h3FF, 0, 1);
    drain();
    cycle(1, 1, 10'h3FF, 128'hDEAD0000111122223333444455BEEF, 1);
    cycle(1, 0, 10'h3FF, 0, 1);
    drain();
    for (int i = 0; i < 16; i++) cycle(1, 1, 10'(i), 128'(i), 1);
    for (int i = 0; i < 16; i++) cycle(1, 0, 10'(i), 0, 1);
    drain();
    for (int i = 0; i < 4; i++) cycle(1, 0, 10'(i), 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 10'(i + 4), 0, 1);
    drain();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 10'($urandom_range(0, 31)),
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1) == 1);
    drain();
    cycle(1, 0, 10'd1, 0, 0);
    cycle(1, 0, 10'd2, 0, 0);
    cycle(0, 0, 0, 0, 0);
    #2 RST = 1;
    #1;
    chk("rst_flush", {127'd0, rsp_vld}, 128'd0);
    chk("rst_flush_data", rsp_data, 128'd0);
    exp_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    sweep();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 10'd5, 0, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
